// File: rtl/naive_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// naive_bus_arbiter_2to1
//
// Shares one naive_bus slave port between two naive_bus masters so that a
// single-port RAM can serve both core buses:
//   m0 = core data bus (fixed priority, a data stall stalls the pipeline)
//   m1 = core instruction bus (forced in after STARVE_LIMIT lost cycles)
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   mX_rd_req/gnt       master X read handshake
//   mX_rd_addr          master X read address (AW)
//   mX_rd_data          master X read data, valid the cycle after mX_rd_gnt
//   mX_wr_req/gnt       master X write handshake
//   mX_wr_addr/data     master X write address (AW) / data (DW)
//   s_rd_req/gnt        slave read handshake
//   s_rd_addr           slave read address
//   s_rd_data           slave read data, valid the cycle after s_rd_gnt
//   s_wr_req/gnt        slave write handshake
//   s_wr_addr/data      slave write address / data
//   o_sel               master selected this cycle (0 = m0, 1 = m1)
// -----------------------------------------------------------------------------
module naive_bus_arbiter_2to1 #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          m0_rd_req,
  output logic          m0_rd_gnt,
  input  logic [AW-1:0] m0_rd_addr,
  output logic [DW-1:0] m0_rd_data,
  input  logic          m0_wr_req,
  output logic          m0_wr_gnt,
  input  logic [AW-1:0] m0_wr_addr,
  input  logic [DW-1:0] m0_wr_data,

  input  logic          m1_rd_req,
  output logic          m1_rd_gnt,
  input  logic [AW-1:0] m1_rd_addr,
  output logic [DW-1:0] m1_rd_data,
  input  logic          m1_wr_req,
  output logic          m1_wr_gnt,
  input  logic [AW-1:0] m1_wr_addr,
  input  logic [DW-1:0] m1_wr_data,

  output logic          s_rd_req,
  input  logic          s_rd_gnt,
  output logic [AW-1:0] s_rd_addr,
  input  logic [DW-1:0] s_rd_data,
  output logic          s_wr_req,
  input  logic          s_wr_gnt,
  output logic [AW-1:0] s_wr_addr,
  output logic [DW-1:0] s_wr_data,

  output logic          o_sel
);

  localparam logic [3:0] LP_LIMIT = 4'(STARVE_LIMIT);

  logic       r_hold_vld;
  logic       r_hold_sel;
  logic [3:0] r_starve_cnt;
  logic       r_rd_vld;
  logic       r_rd_owner;

  logic       w_m0_req;
  logic       w_m1_req;
  logic       w_sel;
  logic       w_stall;
  logic       w_m1_gnt_any;
  logic [3:0] w_starve_nxt;

  assign w_m0_req = m0_rd_req | m0_wr_req;
  assign w_m1_req = m1_rd_req | m1_wr_req;

  // Selection: a stalled transfer keeps its master, then the starvation
  // force for m1, then fixed priority to m0.
  always_comb begin
    w_sel = 1'b0;
    if (r_hold_vld) begin
      w_sel = r_hold_sel;
    end else if ((r_starve_cnt == LP_LIMIT) && w_m1_req) begin
      w_sel = 1'b1;
    end else if (w_m0_req) begin
      w_sel = 1'b0;
    end else if (w_m1_req) begin
      w_sel = 1'b1;
    end
  end

  assign o_sel = w_sel;

  // Zero-latency forwarding of the selected master to the slave port.
  assign s_rd_req  = w_sel ? m1_rd_req  : m0_rd_req;
  assign s_rd_addr = w_sel ? m1_rd_addr : m0_rd_addr;
  assign s_wr_req  = w_sel ? m1_wr_req  : m0_wr_req;
  assign s_wr_addr = w_sel ? m1_wr_addr : m0_wr_addr;
  assign s_wr_data = w_sel ? m1_wr_data : m0_wr_data;

  assign m0_rd_gnt = ~w_sel & s_rd_gnt;
  assign m0_wr_gnt = ~w_sel & s_wr_gnt;
  assign m1_rd_gnt =  w_sel & s_rd_gnt;
  assign m1_wr_gnt =  w_sel & s_wr_gnt;

  // The selected master is being withheld by the slave on either channel.
  assign w_stall = (s_rd_req & ~s_rd_gnt) | (s_wr_req & ~s_wr_gnt);

  assign w_m1_gnt_any = m1_rd_gnt | m1_wr_gnt;

  always_comb begin
    w_starve_nxt = r_starve_cnt;
    if (!w_m1_req) begin
      w_starve_nxt = 4'd0;
    end else if (w_sel && w_m1_gnt_any) begin
      w_starve_nxt = 4'd0;
    end else if (!w_sel && (r_starve_cnt != LP_LIMIT)) begin
      w_starve_nxt = r_starve_cnt + 4'd1;
    end
  end

  // Arbitration state: hold, starvation count, read-return ownership.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_vld   <= 1'b0;
      r_hold_sel   <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_rd_vld     <= 1'b0;
      r_rd_owner   <= 1'b0;
    end else begin
      r_hold_vld   <= w_stall;
      r_hold_sel   <= w_stall ? w_sel : 1'b0;
      r_starve_cnt <= w_starve_nxt;
      r_rd_vld     <= s_rd_req & s_rd_gnt;
      r_rd_owner   <= w_sel;
    end
  end

  // Read return is steered by the registered owner, not the current
  // selection, so back-to-back reads from alternating masters work.
  assign m0_rd_data = (r_rd_vld && !r_rd_owner) ? s_rd_data : '0;
  assign m1_rd_data = (r_rd_vld &&  r_rd_owner) ? s_rd_data : '0;

endmodule

// File: tb/tb_naive_bus_arbiter_2to1.sv
// -----------------------------------------------------------------------------
// tb_naive_bus_arbiter_2to1
//
// Directed bench for naive_bus_arbiter_2to1 (AW = DW = 32, STARVE_LIMIT = 4).
// Inputs change 1 ns after the rising edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_naive_bus_arbiter_2to1;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_rd_req, m0_rd_gnt, m0_wr_req, m0_wr_gnt;
  logic [AW-1:0] m0_rd_addr, m0_wr_addr;
  logic [DW-1:0] m0_rd_data, m0_wr_data;
  logic          m1_rd_req, m1_rd_gnt, m1_wr_req, m1_wr_gnt;
  logic [AW-1:0] m1_rd_addr, m1_wr_addr;
  logic [DW-1:0] m1_rd_data, m1_wr_data;
  logic          s_rd_req, s_rd_gnt, s_wr_req, s_wr_gnt;
  logic [AW-1:0] s_rd_addr, s_wr_addr;
  logic [DW-1:0] s_rd_data, s_wr_data;
  logic          o_sel;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  naive_bus_arbiter_2to1 #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .m0_rd_req(m0_rd_req), .m0_rd_gnt(m0_rd_gnt), .m0_rd_addr(m0_rd_addr),
    .m0_rd_data(m0_rd_data), .m0_wr_req(m0_wr_req), .m0_wr_gnt(m0_wr_gnt),
    .m0_wr_addr(m0_wr_addr), .m0_wr_data(m0_wr_data),
    .m1_rd_req(m1_rd_req), .m1_rd_gnt(m1_rd_gnt), .m1_rd_addr(m1_rd_addr),
    .m1_rd_data(m1_rd_data), .m1_wr_req(m1_wr_req), .m1_wr_gnt(m1_wr_gnt),
    .m1_wr_addr(m1_wr_addr), .m1_wr_data(m1_wr_data),
    .s_rd_req(s_rd_req), .s_rd_gnt(s_rd_gnt), .s_rd_addr(s_rd_addr),
    .s_rd_data(s_rd_data), .s_wr_req(s_wr_req), .s_wr_gnt(s_wr_gnt),
    .s_wr_addr(s_wr_addr), .s_wr_data(s_wr_data),
    .o_sel(o_sel)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_rd_req = 0; m0_wr_req = 0; m1_rd_req = 0; m1_wr_req = 0;
    s_rd_gnt  = 0; s_wr_gnt  = 0;
  endtask

  int exp_sel[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};

  initial begin
    rst = 1;
    idle();
    m0_rd_addr = '0; m0_wr_addr = '0; m0_wr_data = '0;
    m1_rd_addr = '0; m1_wr_addr = '0; m1_wr_data = '0;
    s_rd_data  = '0;
    step(); step();
    rst = 0;

    // Reset state
    #1;
    chk("rst_sel", o_sel, 0);
    chk("rst_m0_rd_data", m0_rd_data, 0);
    chk("rst_m1_rd_data", m1_rd_data, 0);
    chk("rst_s_rd_req", s_rd_req, 0);
    step();

    // Single m0 read, data returned next cycle
    m0_rd_req = 1; m0_rd_addr = 32'h100; s_rd_gnt = 1;
    #1;
    chk("rd1_m0_gnt", m0_rd_gnt, 1);
    chk("rd1_m1_gnt", m1_rd_gnt, 0);
    chk("rd1_addr", s_rd_addr, 32'h100);
    chk("rd1_sel", o_sel, 0);
    step();
    m0_rd_req = 0; s_rd_gnt = 0; s_rd_data = 32'hDEADBEEF;
    #1;
    chk("rd1_m0_data", m0_rd_data, 32'hDEADBEEF);
    chk("rd1_m1_data", m1_rd_data, 0);
    step();
    #1;
    chk("rd1_m0_data_gone", m0_rd_data, 0);
    step();

    // Starvation: both request, slave always grants
    m0_rd_req = 1; m0_rd_addr = 32'hA0;
    m1_rd_req = 1; m1_rd_addr = 32'hB0;
    s_rd_gnt = 1; s_rd_data = '0;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("starve_sel%0d", i), o_sel, exp_sel[i]);
      chk($sformatf("starve_addr%0d", i), s_rd_addr, exp_sel[i] ? 32'hB0 : 32'hA0);
      step();
    end
    idle();
    step();

    // Hold: m1 stalled for 3 cycles while m0 starts requesting
    m1_rd_req = 1; m1_rd_addr = 32'h30; s_rd_gnt = 0;
    #1;
    chk("hold_c1_sel", o_sel, 1);
    chk("hold_c1_m1_gnt", m1_rd_gnt, 0);
    step();
    m0_rd_req = 1; m0_rd_addr = 32'h31;
    #1;
    chk("hold_c2_sel", o_sel, 1);
    chk("hold_c2_m0_gnt", m0_rd_gnt, 0);
    chk("hold_c2_addr", s_rd_addr, 32'h30);
    step();
    #1;
    chk("hold_c3_sel", o_sel, 1);
    step();
    s_rd_gnt = 1;
    #1;
    chk("hold_c4_sel", o_sel, 1);
    chk("hold_c4_m1_gnt", m1_rd_gnt, 1);
    step();
    s_rd_data = 32'h33;
    #1;
    chk("hold_c5_sel", o_sel, 0);
    chk("hold_c5_m0_gnt", m0_rd_gnt, 1);
    chk("hold_c5_m1_data", m1_rd_data, 32'h33);
    chk("hold_c5_m0_data", m0_rd_data, 0);
    step();
    idle();
    step();
    step();

    // Alternating reads m0 then m1
    m0_rd_req = 1; m0_rd_addr = 32'h10; s_rd_gnt = 1;
    #1;
    chk("alt_c1_sel", o_sel, 0);
    chk("alt_c1_m0_gnt", m0_rd_gnt, 1);
    step();
    m0_rd_req = 0; m1_rd_req = 1; m1_rd_addr = 32'h20; s_rd_data = 32'h11;
    #1;
    chk("alt_c2_sel", o_sel, 1);
    chk("alt_c2_addr", s_rd_addr, 32'h20);
    chk("alt_c2_m0_data", m0_rd_data, 32'h11);
    chk("alt_c2_m1_data", m1_rd_data, 0);
    step();
    m1_rd_req = 0; s_rd_gnt = 0; s_rd_data = 32'h22;
    #1;
    chk("alt_c3_m1_data", m1_rd_data, 32'h22);
    chk("alt_c3_m0_data", m0_rd_data, 0);
    step();
    #1;
    chk("alt_c4_m1_data", m1_rd_data, 0);
    chk("alt_c4_m0_data", m0_rd_data, 0);
    step();

    // m0 write, first stalled then granted
    m0_wr_req = 1; m0_wr_addr = 32'h40; m0_wr_data = 32'h5A5A5A5A; s_wr_gnt = 0;
    #1;
    chk("wr_s_req", s_wr_req, 1);
    chk("wr_addr", s_wr_addr, 32'h40);
    chk("wr_data", s_wr_data, 32'h5A5A5A5A);
    chk("wr_m0_gnt_lo", m0_wr_gnt, 0);
    chk("wr_m1_gnt_lo", m1_wr_gnt, 0);
    step();
    s_wr_gnt = 1;
    #1;
    chk("wr_m0_gnt_hi", m0_wr_gnt, 1);
    chk("wr_m1_gnt_hi", m1_wr_gnt, 0);
    step();
    idle();
    step();

    // m1 read and write in the same cycle
    m1_rd_req = 1; m1_rd_addr = 32'h50; m1_wr_req = 1; m1_wr_addr = 32'h60;
    m1_wr_data = 32'h12345678; s_rd_gnt = 1; s_wr_gnt = 1;
    #1;
    chk("rw_sel", o_sel, 1);
    chk("rw_s_rd_req", s_rd_req, 1);
    chk("rw_s_wr_req", s_wr_req, 1);
    chk("rw_m1_rd_gnt", m1_rd_gnt, 1);
    chk("rw_m1_wr_gnt", m1_wr_gnt, 1);
    chk("rw_wr_data", s_wr_data, 32'h12345678);
    step();
    idle();
    step();

    // Hold beats the starvation force; force applies once the hold lifts
    m0_rd_req = 1; m0_rd_addr = 32'h70; m1_rd_req = 1; m1_rd_addr = 32'h80;
    s_rd_gnt = 0;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("hf_stall_sel%0d", i), o_sel, 0);
      step();
    end
    s_rd_gnt = 1;
    #1;
    chk("hf_grant_sel", o_sel, 0);
    chk("hf_grant_m0_gnt", m0_rd_gnt, 1);
    step();
    #1;
    chk("hf_force_sel", o_sel, 1);
    chk("hf_force_m1_gnt", m1_rd_gnt, 1);
    step();
    idle();
    step();

    // Reset while m0 is held and the starvation count is 3
    m0_rd_req = 1; m0_rd_addr = 32'h90; m1_rd_req = 1; m1_rd_addr = 32'h94;
    s_rd_gnt = 1;
    step();
    step();
    s_rd_gnt = 0;
    #1;
    chk("rs_stall_sel", o_sel, 0);
    step();
    rst = 1; s_rd_gnt = 1;
    step();
    rst = 0; s_rd_data = 32'hBAD0BAD0;
    #1;
    chk("rs_after_sel", o_sel, 0);
    chk("rs_after_m0_data", m0_rd_data, 0);
    chk("rs_after_m1_data", m1_rd_data, 0);
    step();
    #1;
    chk("rs_cnt_cleared_sel", o_sel, 0);
    step();
    m0_rd_req = 0;
    #1;
    chk("rs_m0_idle_sel", o_sel, 1);
    chk("rs_m0_idle_m1_gnt", m1_rd_gnt, 1);
    step();
    idle();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
